cmd_frame_ctrl: RTL and testbench
=================================

Name: cmd_frame_ctrl

Overview:
Parametrised successor of the system controller. It decodes UART command frames into register-file and ALU transactions, then streams responses back to the UART TX path. It generalises data width, register address width and ALU result width, with multi-byte result serialisation. New over the previous generation: a per-frame inter-byte timeout, error flagging of unknown commands, and a Busy-tracked TX handshake. It sits in the REF_CLK domain between the RX/TX data synchronisers, RegFile and ALU.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and register data
ADDR_WIDTH, 4, register-file address width; the address byte is truncated to its low ADDR_WIDTH bits
RESULT_WIDTH, 16, ALU result width; serialised as NB = ceil(RESULT_WIDTH/DATA_WIDTH) bytes
FUN_WIDTH, 4, ALU function code width
TIMEOUT_CYCLES, 255, maximum idle cycles allowed inside a frame or response wait

Ports:
CLK  input  1  system clock, all logic on the rising edge
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  synchronised RX byte
RX_D_VLD  input  1  one-cycle strobe; RX_P_DATA is valid
RdData  input  DATA_WIDTH  register-file read data
RdData_Valid  input  1  read data strobe
ALU_OUT  input  RESULT_WIDTH  ALU result
OUT_Valid  input  1  ALU result strobe
Busy  input  1  synchronised UART TX busy
WrEn  output  1  register write strobe
RdEn  output  1  register read strobe
Address  output  ADDR_WIDTH  register address
WrData  output  DATA_WIDTH  register write data
ALU_EN  output  1  one-cycle ALU start
ALU_FUN  output  FUN_WIDTH  ALU operation
CLK_EN  output  1  ALU clock-gate enable
TX_P_DATA  output  DATA_WIDTH  byte to transmit
TX_D_VLD  output  1  one-cycle TX request
clk_div_en  output  1  TX clock divider enable
frame_err  output  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0 except clk_div_en. clk_div_en is 0 during reset and is held 1 from the first clock after reset release. FSM returns to IDLE.
- Commands are decoded in IDLE on RX_D_VLD:
  - 0xAA: register write; frame is ADDR, DATA.
  - 0xBB: register read; frame is ADDR.
  - 0xCC: ALU op with operands; frame is A, B, FUN.
  - 0xDD: ALU op without operands; frame is FUN.
  - Any other byte: frame_err pulse next cycle, stay in IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_BYTE, TX_HOLD.
- Write path: the DATA byte produces WrEn=1 for exactly one cycle, with Address/WrData stable that cycle. Then IDLE.
- Operand path: OP_A writes the byte to address 0 and OP_B writes to address 1. Each is a one-cycle WrEn pulse.
- Read path: on the ADDR byte, RdEn pulses for one cycle, then RD_WAIT. On RdData_Valid, RdData is captured, a 1-byte response is queued, and the FSM enters TX_BYTE.
- ALU path: on the FUN byte, ALU_FUN is latched (low FUN_WIDTH bits), ALU_EN pulses for one cycle and CLK_EN rises the same cycle. In ALU_WAIT, CLK_EN stays 1. On OUT_Valid, ALU_OUT is captured zero-padded to NB*DATA_WIDTH bits, CLK_EN drops the next cycle, and NB bytes are queued LSB byte first.
- TX handshake:
  - In TX_BYTE, when Busy=0, TX_P_DATA is driven with the current byte and TX_D_VLD pulses for one cycle. The FSM then enters TX_HOLD.
  - TX_HOLD requires Busy to be seen 1 and then 0.
  - After that, the next byte goes out, or the FSM returns to IDLE after byte NB.
  - TX_P_DATA holds its value until the next TX_D_VLD.
- RX_D_VLD arriving during RD_WAIT, ALU_WAIT, TX_BYTE or TX_HOLD is dropped.
- Timeout: a counter clears on every state change and on every RX_D_VLD. In any state other than IDLE, if it reaches TIMEOUT_CYCLES:
  - frame_err pulses.
  - CLK_EN drops.
  - The FSM goes to IDLE.
  - No further strobes are issued for that frame.
- Simultaneous: OUT_Valid in the same cycle as a timeout counts as success (the response is sent). Reset mid-frame aborts immediately with all strobes cleared.

Test Plan:
- Frame AA 05 3C -> one WrEn cycle, Address=5, WrData=0x3C. No TX_D_VLD, no frame_err.
- Frame BB 05, RdData=0x3C returned 2 cycles after RdEn -> TX_D_VLD once with TX_P_DATA=0x3C. Then IDLE.
- Frame CC 0A 14 00 with ALU_OUT=0x001E -> WrEn at addr 0 (0x0A) and addr 1 (0x14), then ALU_EN with FUN=0. TX order 0x1E, then 0x00 only after Busy high→low. CLK_EN falls one cycle after OUT_Valid.
- RESULT_WIDTH=20, frame DD 02 with ALU_OUT=0xABCDE -> three bytes DE, BC, 0A.
- Bytes AA 03, then silence for 255 cycles -> frame_err pulse, no WrEn. Next frame AA 01 77 completes normally.
- Byte 0x55 in IDLE -> frame_err one cycle, all other outputs idle. RST asserted during ALU_WAIT -> CLK_EN=0 immediately, FSM in IDLE after release.

Source files
------------

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes UART RX command frames into RegFile and ALU
// transactions and serialises the responses back onto the UART TX path.
module cmd_frame_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned RESULT_WIDTH   = 16,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [RESULT_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    Busy,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    clk_div_en,
    output logic                    frame_err
);

    localparam int unsigned NB     = (RESULT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned PAD_W  = NB * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LEFT_W = $clog2(NB + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);
    localparam logic [CNT_W-1:0]      TMO_MAX    = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_BYTE,
        ST_TX_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic                    clk_en_q, clk_en_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    clk_div_en_q, clk_div_en_d;
    logic                    frame_err_q, frame_err_d;
    logic [PAD_W-1:0]        result_q, result_d;
    logic [LEFT_W-1:0]       bytes_left_q, bytes_left_d;
    logic                    busy_seen_q, busy_seen_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        clk_en_d     = clk_en_q;
        tx_data_d    = tx_data_q;
        tx_vld_d     = 1'b0;
        clk_div_en_d = 1'b1;
        frame_err_d  = 1'b0;
        result_d     = result_q;
        bytes_left_d = bytes_left_q;
        busy_seen_d  = busy_seen_q;

        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    unique case (RX_P_DATA)
                        CMD_WR:     state_d = ST_WR_ADDR;
                        CMD_RD:     state_d = ST_RD_ADDR;
                        CMD_ALU_OP: state_d = ST_OP_A;
                        CMD_ALU_NO: state_d = ST_ALU_FUN;
                        default:    frame_err_d = 1'b1;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(RX_P_DATA);
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(RX_P_DATA);
                    rd_en_d = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (RdData_Valid) begin
                    result_d     = PAD_W'(RdData);
                    bytes_left_d = LEFT_W'(1);
                    state_d      = ST_TX_BYTE;
                end
            end
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    addr_d    = '0;
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    addr_d    = ADDR_WIDTH'(1);
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = FUN_WIDTH'(RX_P_DATA);
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (OUT_Valid) begin
                    result_d     = PAD_W'(ALU_OUT);
                    bytes_left_d = LEFT_W'(NB);
                    clk_en_d     = 1'b0;
                    state_d      = ST_TX_BYTE;
                end
            end
            ST_TX_BYTE: begin
                // Result register shifts down so the next byte is always at the bottom
                if (!Busy) begin
                    tx_data_d    = result_q[DATA_WIDTH-1:0];
                    tx_vld_d     = 1'b1;
                    result_d     = result_q >> DATA_WIDTH;
                    bytes_left_d = bytes_left_q - LEFT_W'(1);
                    busy_seen_d  = 1'b0;
                    state_d      = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: begin
                if (busy_seen_q && !Busy) begin
                    state_d = (bytes_left_q == '0) ? ST_IDLE : ST_TX_BYTE;
                end else if (Busy) begin
                    busy_seen_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout only aborts when the frame made no progress this cycle
        if (state_q != ST_IDLE && state_d == state_q && tmo_cnt_q == TMO_MAX) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            clk_en_d    = 1'b0;
        end

        if (state_d != state_q || RX_D_VLD) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            tmo_cnt_q    <= '0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            clk_en_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
            clk_div_en_q <= 1'b0;
            frame_err_q  <= 1'b0;
            result_q     <= '0;
            bytes_left_q <= '0;
            busy_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            clk_en_q     <= clk_en_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
            clk_div_en_q <= clk_div_en_d;
            frame_err_q  <= frame_err_d;
            result_q     <= result_d;
            bytes_left_q <= bytes_left_d;
            busy_seen_q  <= busy_seen_d;
        end
    end

    assign WrEn       = wr_en_q;
    assign RdEn       = rd_en_q;
    assign Address    = addr_q;
    assign WrData     = wr_data_q;
    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign CLK_EN     = clk_en_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign clk_div_en = clk_div_en_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed bench for cmd_frame_ctrl: a 16-bit-result instance plus a 20-bit-result
// instance for three-byte serialisation.
module tb_cmd_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic        rx_vld2 = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic [19:0] alu_out2 = '0;
    logic        out_valid2 = 1'b0;
    logic        Busy = 1'b0;

    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, clk_div_en, frame_err;
    logic [3:0]  Address, ALU_FUN;
    logic [7:0]  WrData, TX_P_DATA;

    logic        wr_en2, rd_en2, alu_en2, clk_en2, tx_vld2, clk_div_en2, frame_err2;
    logic [3:0]  addr2, alu_fun2;
    logic [7:0]  wr_data2, tx_data2;

    int total = 0;
    int bad   = 0;

    int         wr_cnt = 0, err_cnt = 0, tx_cnt = 0, tx2_cnt = 0, alu_cnt = 0;
    logic [7:0] tx_log  [16];
    logic [7:0] tx2_log [16];

    always #5 CLK = ~CLK;

    cmd_frame_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .RESULT_WIDTH(16), .FUN_WIDTH(4), .TIMEOUT_CYCLES(255)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
        .OUT_Valid(OUT_Valid), .Busy(Busy), .WrEn(WrEn), .RdEn(RdEn),
        .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .clk_div_en(clk_div_en), .frame_err(frame_err)
    );

    cmd_frame_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .RESULT_WIDTH(20), .FUN_WIDTH(4), .TIMEOUT_CYCLES(255)
    ) dut20 (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(rx_vld2),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(alu_out2),
        .OUT_Valid(out_valid2), .Busy(Busy), .WrEn(wr_en2), .RdEn(rd_en2),
        .Address(addr2), .WrData(wr_data2), .ALU_EN(alu_en2), .ALU_FUN(alu_fun2),
        .CLK_EN(clk_en2), .TX_P_DATA(tx_data2), .TX_D_VLD(tx_vld2),
        .clk_div_en(clk_div_en2), .frame_err(frame_err2)
    );

    // Pulse counters and TX byte logs, sampled mid-cycle
    always @(negedge CLK) begin
        if (WrEn === 1'b1)      wr_cnt  <= wr_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (ALU_EN === 1'b1)    alu_cnt <= alu_cnt + 1;
        if (TX_D_VLD === 1'b1) begin
            tx_log[tx_cnt % 16] <= TX_P_DATA;
            tx_cnt <= tx_cnt + 1;
        end
        if (tx_vld2 === 1'b1) begin
            tx2_log[tx2_cnt % 16] <= tx_data2;
            tx2_cnt <= tx2_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit to2);
        RX_P_DATA = b;
        if (to2) rx_vld2 = 1'b1; else RX_D_VLD = 1'b1;
        tick();
        RX_D_VLD = 1'b0;
        rx_vld2  = 1'b0;
    endtask

    // UART sink: answers each TX_D_VLD with a Busy pulse and flags any early request
    task automatic run_tx(input bit use2, input int nbytes, output int got);
        int budget;
        got    = 0;
        budget = 0;
        while (got < nbytes && budget < 300) begin
            tick();
            budget++;
            if ((use2 ? tx_vld2 : TX_D_VLD) === 1'b1) begin
                got++;
                Busy = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    tick();
                    budget++;
                    total++;
                    if ((use2 ? tx_vld2 : TX_D_VLD) !== 1'b0) begin
                        bad++;
                        $display("FAIL tx_while_busy: TX_D_VLD=%b want 0", use2 ? tx_vld2 : TX_D_VLD);
                    end
                end
                Busy = 1'b0;
            end
        end
        total++;
        if (got != nbytes) begin
            bad++;
            $display("FAIL tx_count: got %0d bytes want %0d", got, nbytes);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if ({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, frame_err} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000000", {WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, frame_err});
        end
        total++; if ({Address, WrData, ALU_FUN, TX_P_DATA} !== 24'h0) begin
            bad++; $display("FAIL reset_data: got %h want 000000", {Address, WrData, ALU_FUN, TX_P_DATA});
        end
        total++; if (clk_div_en !== 1'b0) begin
            bad++; $display("FAIL reset_clk_div_en: got %b want 0", clk_div_en);
        end
        RST = 1'b1;
        tick();
        total++; if (clk_div_en !== 1'b1) begin
            bad++; $display("FAIL clk_div_en_release: got %b want 1", clk_div_en);
        end
        tick();
    endtask

    task automatic test_write();
        int wr0, err0, tx0;
        wr0 = wr_cnt; err0 = err_cnt; tx0 = tx_cnt;
        send_byte(8'hAA, 0); tick();
        send_byte(8'h05, 0); tick(); tick();
        send_byte(8'h3C, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            bad++; $display("FAIL write_strobe: got en=%b a=%h d=%h want en=1 a=5 d=3c", WrEn, Address, WrData);
        end
        tick();
        total++; if (WrEn !== 1'b0) begin
            bad++; $display("FAIL write_one_cycle: WrEn=%b want 0", WrEn);
        end
        repeat (3) tick();
        total++; if (wr_cnt - wr0 != 1 || err_cnt != err0 || tx_cnt != tx0) begin
            bad++; $display("FAIL write_side_effects: wr=%0d err=%0d tx=%0d want 1 0 0", wr_cnt - wr0, err_cnt - err0, tx_cnt - tx0);
        end
    endtask

    task automatic test_read();
        int tx0, got;
        tx0 = tx_cnt;
        send_byte(8'hBB, 0);
        send_byte(8'h05, 0);
        total++; if ({RdEn, Address} !== {1'b1, 4'h5}) begin
            bad++; $display("FAIL read_strobe: got en=%b a=%h want en=1 a=5", RdEn, Address);
        end
        tick();
        total++; if (RdEn !== 1'b0) begin
            bad++; $display("FAIL read_one_cycle: RdEn=%b want 0", RdEn);
        end
        RdData = 8'h3C; RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        run_tx(0, 1, got);
        repeat (5) tick();
        total++; if (tx_cnt - tx0 != 1 || tx_log[tx0 % 16] !== 8'h3C) begin
            bad++; $display("FAIL read_response: n=%0d byte=%h want n=1 byte=3c", tx_cnt - tx0, tx_log[tx0 % 16]);
        end
        total++; if (TX_P_DATA !== 8'h3C) begin
            bad++; $display("FAIL tx_data_hold: got %h want 3c", TX_P_DATA);
        end
    endtask

    task automatic test_alu_operands();
        int tx0, got;
        tx0 = tx_cnt;
        send_byte(8'hCC, 0);
        send_byte(8'h0A, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h0, 8'h0A}) begin
            bad++; $display("FAIL op_a_write: got en=%b a=%h d=%h want en=1 a=0 d=0a", WrEn, Address, WrData);
        end
        send_byte(8'h14, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h14}) begin
            bad++; $display("FAIL op_b_write: got en=%b a=%h d=%h want en=1 a=1 d=14", WrEn, Address, WrData);
        end
        send_byte(8'h00, 0);
        total++; if ({ALU_EN, CLK_EN, ALU_FUN, WrEn} !== {1'b1, 1'b1, 4'h0, 1'b0}) begin
            bad++; $display("FAIL alu_start: got en=%b ck=%b fun=%h wr=%b want 1 1 0 0", ALU_EN, CLK_EN, ALU_FUN, WrEn);
        end
        tick();
        total++; if ({ALU_EN, CLK_EN} !== 2'b01) begin
            bad++; $display("FAIL alu_wait: got en=%b ck=%b want en=0 ck=1", ALU_EN, CLK_EN);
        end
        ALU_OUT = 16'h001E; OUT_Valid = 1'b1;
        #2;
        total++; if (CLK_EN !== 1'b1) begin
            bad++; $display("FAIL clk_en_at_valid: got %b want 1", CLK_EN);
        end
        tick();
        OUT_Valid = 1'b0;
        total++; if (CLK_EN !== 1'b0) begin
            bad++; $display("FAIL clk_en_fall: got %b want 0", CLK_EN);
        end
        run_tx(0, 2, got);
        repeat (5) tick();
        total++; if (tx_cnt - tx0 != 2 || tx_log[tx0 % 16] !== 8'h1E || tx_log[(tx0 + 1) % 16] !== 8'h00) begin
            bad++; $display("FAIL alu_response: n=%0d b0=%h b1=%h want n=2 1e 00",
                            tx_cnt - tx0, tx_log[tx0 % 16], tx_log[(tx0 + 1) % 16]);
        end
    endtask

    task automatic test_wide_result();
        int tx0, got;
        tx0 = tx2_cnt;
        send_byte(8'hDD, 1);
        send_byte(8'h02, 1);
        total++; if ({alu_en2, clk_en2, alu_fun2} !== {1'b1, 1'b1, 4'h2}) begin
            bad++; $display("FAIL wide_alu_start: got en=%b ck=%b fun=%h want 1 1 2", alu_en2, clk_en2, alu_fun2);
        end
        tick();
        alu_out2 = 20'hABCDE; out_valid2 = 1'b1;
        tick();
        out_valid2 = 1'b0;
        run_tx(1, 3, got);
        repeat (5) tick();
        total++; if (tx2_cnt - tx0 != 3 || tx2_log[tx0 % 16] !== 8'hDE ||
                     tx2_log[(tx0 + 1) % 16] !== 8'hBC || tx2_log[(tx0 + 2) % 16] !== 8'h0A) begin
            bad++; $display("FAIL wide_response: n=%0d bytes=%h %h %h want n=3 de bc 0a", tx2_cnt - tx0,
                            tx2_log[tx0 % 16], tx2_log[(tx0 + 1) % 16], tx2_log[(tx0 + 2) % 16]);
        end
    endtask

    task automatic test_timeout();
        int wr0, n;
        wr0 = wr_cnt;
        send_byte(8'hAA, 0);
        send_byte(8'h03, 0);
        n = 0;
        while (frame_err !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        total++; if (n < 255 || n > 257) begin
            bad++; $display("FAIL timeout_latency: frame_err after %0d cycles want 255..257", n);
        end
        total++; if (wr_cnt != wr0 || CLK_EN !== 1'b0) begin
            bad++; $display("FAIL timeout_no_write: wr=%0d ck=%b want 0 0", wr_cnt - wr0, CLK_EN);
        end
        tick();
        total++; if (frame_err !== 1'b0) begin
            bad++; $display("FAIL timeout_pulse: frame_err=%b want 0", frame_err);
        end
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h77}) begin
            bad++; $display("FAIL after_timeout_write: got en=%b a=%h d=%h want en=1 a=1 d=77", WrEn, Address, WrData);
        end
        tick();
    endtask

    task automatic test_bad_cmd();
        send_byte(8'h55, 0);
        total++; if ({frame_err, WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD} !== 6'b100000) begin
            bad++; $display("FAIL bad_cmd: got %b want 100000", {frame_err, WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD});
        end
        tick();
        total++; if (frame_err !== 1'b0) begin
            bad++; $display("FAIL bad_cmd_pulse: frame_err=%b want 0", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hAA, 0);
        send_byte(8'h07, 0);
        send_byte(8'h11, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h7, 8'h11}) begin
            bad++; $display("FAIL b2b_first: got en=%b a=%h d=%h want en=1 a=7 d=11", WrEn, Address, WrData);
        end
        send_byte(8'hAA, 0);
        send_byte(8'h18, 0);
        send_byte(8'h22, 0);
        total++; if ({WrEn, Address, WrData} !== {1'b1, 4'h8, 8'h22}) begin
            bad++; $display("FAIL b2b_second: got en=%b a=%h d=%h want en=1 a=8 d=22", WrEn, Address, WrData);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hDD, 0);
        send_byte(8'h03, 0);
        repeat (3) tick();
        total++; if (CLK_EN !== 1'b1) begin
            bad++; $display("FAIL alu_wait_clk_en: got %b want 1", CLK_EN);
        end
        RST = 1'b0;
        #1;
        total++; if ({CLK_EN, ALU_EN, clk_div_en, ALU_FUN} !== 7'b0) begin
            bad++; $display("FAIL reset_async: got ck=%b en=%b div=%b fun=%h want all 0", CLK_EN, ALU_EN, clk_div_en, ALU_FUN);
        end
        tick();
        RST = 1'b1;
        tick();
        send_byte(8'hAA, 0);
        send_byte(8'h02, 0);
        send_byte(8'h99, 0);
        total++; if ({WrEn, Address, WrData, CLK_EN} !== {1'b1, 4'h2, 8'h99, 1'b0}) begin
            bad++; $display("FAIL after_reset_write: got en=%b a=%h d=%h ck=%b want 1 2 99 0", WrEn, Address, WrData, CLK_EN);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_operands();
        test_wide_result();
        test_timeout();
        test_bad_cmd();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
